// File: rtl/output_argmax.sv
// Argmax classifier head: captures a vector of signed scores and scans them one per cycle.
// Optional macro ARGMAX_MAX_OUT_EN adds the o_max port carrying the winning score.
module output_argmax #(
   parameter int  NUM_INPUTS = 10,
   parameter int  DATAWIDTH  = 16,
   localparam int IDXW       = $clog2(NUM_INPUTS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATAWIDTH*NUM_INPUTS-1:0] i_data,
   input  logic                            i_valid,
   output logic [IDXW-1:0]                 o_digit,
   output logic                            o_valid,
   output logic                            o_busy
`ifdef ARGMAX_MAX_OUT_EN
   ,
   output logic [DATAWIDTH-1:0]            o_max
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [DATAWIDTH-1:0]  r_buf [NUM_INPUTS];
   logic [DATAWIDTH-1:0]  r_max;
   logic [IDXW-1:0]       r_idx;
   logic [IDXW-1:0]       r_cnt;
   logic [IDXW-1:0]       r_digit;
   logic                  r_valid;
   logic                  r_busy;
   logic                  w_capture;
   logic                  w_last;
   logic                  w_gt;
   logic [DATAWIDTH-1:0]  w_cand;
`ifdef ARGMAX_MAX_OUT_EN
   logic [DATAWIDTH-1:0]  r_omax;
`endif

   // A new vector is accepted from IDLE or DONE; strobes during SCAN are dropped.
   assign w_capture = i_valid && (r_state != ST_SCAN);
   assign w_last    = (r_cnt == IDXW'(NUM_INPUTS - 1));
   assign w_cand    = r_buf[r_cnt];
   assign w_gt      = $signed(w_cand) > $signed(r_max);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_valid) w_next = ST_SCAN;
            else         w_next = ST_IDLE;
         end
         ST_SCAN: begin
            if (w_last) w_next = ST_DONE;
            else        w_next = ST_SCAN;
         end
         ST_DONE: begin
            if (i_valid) w_next = ST_SCAN;
            else         w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Capture, sequential compare and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_INPUTS; k++) r_buf[k] <= '0;
         r_max   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_digit <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
`ifdef ARGMAX_MAX_OUT_EN
         r_omax  <= '0;
`endif
      end else begin
         r_valid <= (w_next == ST_DONE);
         r_busy  <= (w_next == ST_SCAN);
         if (w_capture) begin
            for (int k = 0; k < NUM_INPUTS; k++) r_buf[k] <= i_data[k*DATAWIDTH +: DATAWIDTH];
            r_max <= i_data[DATAWIDTH-1:0];
            r_idx <= '0;
            r_cnt <= IDXW'(1);
         end else if (r_state == ST_SCAN) begin
            // Strict greater-than keeps the lowest index among equal maxima.
            if (w_gt) begin
               r_max <= w_cand;
               r_idx <= r_cnt;
            end
            r_cnt <= r_cnt + IDXW'(1);
            if (w_last) begin
               r_digit <= w_gt ? r_cnt : r_idx;
`ifdef ARGMAX_MAX_OUT_EN
               r_omax  <= w_gt ? w_cand : r_max;
`endif
            end
         end
      end
   end

   assign o_digit = r_digit;
   assign o_valid = r_valid;
   assign o_busy  = r_busy;
`ifdef ARGMAX_MAX_OUT_EN
   assign o_max   = r_omax;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Self-checking bench for output_argmax: latency-based reference model plus directed literal checks.
// Build with ARGMAX_MAX_OUT_EN defined to also check o_max.
module tb_output_argmax;
   localparam int N  = 10;
   localparam int DW = 16;
   localparam int IW = $clog2(N);

   logic              clk;
   logic              rst;
   logic [N*DW-1:0]   i_data;
   logic              i_valid;
   logic [IW-1:0]     o_digit;
   logic              o_valid;
   logic              o_busy;
`ifdef ARGMAX_MAX_OUT_EN
   logic [DW-1:0]     o_max;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Model: age counts cycles since an accepted capture (-1 = no scan outstanding).
   int             age       = -1;
   int             exp_digit = 0;
   logic [DW-1:0]  exp_max   = '0;
   int             pend_digit = 0;
   logic [DW-1:0]  pend_max  = '0;

   output_argmax #(.NUM_INPUTS(N), .DATAWIDTH(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_digit (o_digit),
      .o_valid (o_valid),
      .o_busy  (o_busy)
`ifdef ARGMAX_MAX_OUT_EN
      ,
      .o_max   (o_max)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_argmax(input logic [N*DW-1:0] d);
      int best = 0;
      for (int k = 1; k < N; k++)
         if ($signed(d[k*DW +: DW]) > $signed(d[best*DW +: DW])) best = k;
      return best;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic [N*DW-1:0] d);
      int old;
      if (r) begin
         age = -1; exp_digit = 0; exp_max = '0;
      end else begin
         old = age;
         if (age >= 0 && age <= N) age = age + 1;
         if (age == N) begin
            exp_digit = pend_digit;
            exp_max   = pend_max;
         end
         if (v && (old < 0 || old >= N)) begin
            pend_digit = ref_argmax(d);
            pend_max   = d[pend_digit*DW +: DW];
            age = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("o_valid", 32'(o_valid), 32'(age == N));
      chk("o_busy",  32'(o_busy),  32'(age >= 1 && age < N));
      chk("o_digit", 32'(o_digit), 32'(exp_digit));
`ifdef ARGMAX_MAX_OUT_EN
      chk("o_max",   32'(o_max),   32'(exp_max));
`endif
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass, then check.
   task automatic tick(input logic r, input logic v, input logic [N*DW-1:0] d);
      rst = r; i_valid = v; i_data = d;
      @(negedge clk);
      model_step(r, v, d);
      check_outputs();
   endtask

   function automatic logic [N*DW-1:0] rand_vec();
      logic [N*DW-1:0] d;
      for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, rand_vec());
   endtask

   // Start a scan, wait out the latency, pin the result to hand-computed literals.
   task automatic run_vec(input logic [N*DW-1:0] d, input string name,
                          input int lit_digit, input logic [DW-1:0] lit_max, input int trail);
      tick(1'b0, 1'b1, d);
      idle(N - 1);
      chk({name, "_valid"}, 32'(o_valid), 32'd1);
      chk({name, "_digit"}, 32'(o_digit), 32'(lit_digit));
`ifdef ARGMAX_MAX_OUT_EN
      chk({name, "_max"}, 32'(o_max), 32'(lit_max));
`else
      if (lit_max != pend_max) chk({name, "_refmax"}, 32'(pend_max), 32'(lit_max));
`endif
      idle(trail);
   endtask

   function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
      logic [N*DW-1:0] d;
      for (int k = 0; k < N; k++) d[k*DW +: DW] = v;
      return d;
   endfunction

   initial begin
      logic [N*DW-1:0] v;
      logic [N*DW-1:0] w;
      rst = 1'b1; i_valid = 1'b0; i_data = '0;
      @(negedge clk);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, rand_vec());
      chk("reset_digit", 32'(o_digit), 32'd0);
      chk("reset_busy",  32'(o_busy),  32'd0);
      idle(2);

      // Increasing scores with a peak at index 2
      v = fill(16'h0000);
      v[0*DW +: DW] = 16'h0100; v[1*DW +: DW] = 16'h0200; v[2*DW +: DW] = 16'h0900;
      v[3*DW +: DW] = 16'h0300; v[4*DW +: DW] = 16'h0400; v[5*DW +: DW] = 16'h0500;
      v[6*DW +: DW] = 16'h0600; v[7*DW +: DW] = 16'h0700; v[8*DW +: DW] = 16'h0800;
      run_vec(v, "peak2", 2, 16'h0900, 1);

      // All-negative scores: signed compare must pick index 7
      v = fill(16'h8000);
      v[0*DW +: DW] = 16'hFF00; v[1*DW +: DW] = 16'hF000; v[7*DW +: DW] = 16'hFFF0;
      run_vec(v, "neg7", 7, 16'hFFF0, 1);

      run_vec(fill(16'h0400), "alleq", 0, 16'h0400, 1);
      v = fill(16'h0100);
      v[3*DW +: DW] = 16'h0500; v[8*DW +: DW] = 16'h0500;
      run_vec(v, "tie38", 3, 16'h0500, 1);
      run_vec(fill(16'h8000), "allmin", 0, 16'h8000, 1);

      // Max at last index with a second strobe mid-scan
      v = fill(16'h1234);
      v[9*DW +: DW] = 16'h7FFF;
      w = fill(16'h0000);
      w[0*DW +: DW] = 16'h7FFF;
      tick(1'b0, 1'b1, v);
      idle(3);
      tick(1'b0, 1'b1, w);
      idle(5);
      chk("last9_valid", 32'(o_valid), 32'd1);
      chk("last9_digit", 32'(o_digit), 32'd9);
      idle(3);

      // Back-to-back: strobe in the DONE cycle of the previous result
      v = fill(16'h0010); v[4*DW +: DW] = 16'h0020;
      w = fill(16'hFFFF); w[6*DW +: DW] = 16'h0001;
      run_vec(v, "b2b_a", 4, 16'h0020, 0);
      run_vec(w, "b2b_b", 6, 16'h0001, 2);

      // Reset in the middle of a scan
      tick(1'b0, 1'b1, v);
      idle(4);
      tick(1'b1, 1'b0, rand_vec());
      chk("rstmid_busy",  32'(o_busy),  32'd0);
      chk("rstmid_valid", 32'(o_valid), 32'd0);
      chk("rstmid_digit", 32'(o_digit), 32'd0);
      idle(N + 2);
      run_vec(w, "after_rst", 6, 16'h0001, 1);

      // Reset and strobe together: nothing captured
      tick(1'b1, 1'b1, v);
      idle(N + 2);

      // Randomized traffic, including small-range scores to force ties
      for (int i = 0; i < 4000; i++) begin
         logic r;
         logic vv;
         logic [N*DW-1:0] d;
         r  = ($urandom_range(0, 199) == 0);
         vv = ($urandom_range(0, 2) == 0);
         d  = rand_vec();
         if ($urandom_range(0, 1) == 1)
            for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom_range(0, 3)) - 16'd2;
         tick(r, vv, d);
      end
      idle(N + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
